// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and constants for the common data bus arbiter. These mirror
//   the sys_defs definitions used across the out-of-order core so that the
//   reservation station and map table can consume `cdb` directly.
//
//   Contents:
//     TAG_W            width of a physical destination tag
//     NUM_CDB_REQ      number of functional units competing for the CDB
//     CDB_REQ_*        requester index constants (ALU, MULT, LD)
//     TAG              broadcast record {tag, ready, valid}
//     CDB_REQ          buffered result record {valid, tag, value}
//     TAG_IDLE         the "nothing on the bus" broadcast value
//     ptr_width()      width of a pointer that indexes n requesters
package cdb_arbiter_pkg;

  localparam int unsigned TAG_W = 6;

  localparam int unsigned NUM_CDB_REQ  = 3;
  localparam int unsigned CDB_REQ_ALU  = 0;
  localparam int unsigned CDB_REQ_MULT = 1;
  localparam int unsigned CDB_REQ_LD   = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
    logic             valid;
  } TAG;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
  } CDB_REQ;

  localparam TAG TAG_IDLE = '{tag: '0, ready: 1'b0, valid: 1'b0};

  // A single requester still needs a 1-bit pointer so that port widths stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// cdb_rr_pick
//   Combinational masked priority picker. Searches the request vector starting
//   at index `start` and wrapping around; the first set bit found wins. With
//   start tied to 0 it degenerates into a fixed lowest-index-first priority
//   encoder.
//
//   Ports:
//     valid  [N-1:0]     candidate request vector
//     start  [PtrW-1:0]  index at which the search begins (must be < N)
//     grant  [N-1:0]     one-hot winner, all zero when no candidate is valid
module cdb_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N    = NUM_CDB_REQ,
  parameter int unsigned PtrW = ptr_width(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [PtrW-1:0] start,
  output logic [N-1:0]    grant
);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // Walk start, start+1, ... modulo N; only the first hit is taken.
      idx = PtrW'((32'(start) + k) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects completed results from the functional units (index 0 = ALU,
//   1 = MULT, 2 = LD) and places exactly one of them per cycle onto the common
//   data bus. Each requester owns a one-entry holding buffer so the unit can
//   hand off its result and continue while it waits for the bus. Arbitration
//   looks only at the buffers, so a fresh request never bypasses straight to
//   the bus: a result sampled at one edge is broadcast at the earliest one edge
//   later.
//
//   Build option:
//     CDB_RR_EN  defined   -> round-robin; the search starts at a pointer that
//                             moves to (winner + 1) mod NUM_REQ on each grant.
//                undefined -> fixed priority, lowest index wins; no pointer.
//
//   Ports:
//     clock      system clock, all state on the rising edge
//     reset      asynchronous active-low reset
//     squash     synchronous flush; drops buffered and outgoing results
//     req_valid  per-unit result valid
//     req_tag    per-unit destination physical tag
//     req_value  per-unit result data
//     req_stall  combinational; the unit must hold its request while high
//     cdb        registered broadcast {tag, ready, valid}
//     cdb_value  registered result data aligned with cdb
//     cdb_grant  registered one-hot source of the current broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_CDB_REQ
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][31:0]       req_value,
  output logic [NUM_REQ-1:0]             req_stall,
  output TAG                             cdb,
  output logic [31:0]                    cdb_value,
  output logic [NUM_REQ-1:0]             cdb_grant
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  // Holding buffers, one per requester.
  CDB_REQ [NUM_REQ-1:0] buf_q, buf_d;
  logic   [NUM_REQ-1:0] buf_valid;

  logic [NUM_REQ-1:0] grant_next;
  logic [NUM_REQ-1:0] accept;
  logic [PtrW-1:0]    ptr_start;

  // Registered bus outputs.
  TAG                 cdb_q, cdb_d;
  logic [31:0]        cdb_value_q, cdb_value_d;
  logic [NUM_REQ-1:0] cdb_grant_q, cdb_grant_d;

`ifdef CDB_RR_EN
  logic [PtrW-1:0] ptr_q, ptr_d;
  assign ptr_start = ptr_q;
`else
  assign ptr_start = '0;
`endif

  always_comb begin
    buf_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      buf_valid[i] = buf_q[i].valid;
    end
  end

  cdb_rr_pick #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_pick (
    .valid (buf_valid),
    .start (ptr_start),
    .grant (grant_next)
  );

  // A full buffer that wins this cycle drains and can refill on the same
  // edge, so only full-and-losing entries push back. During squash everything
  // is being dropped anyway, so nobody is asked to wait.
  assign req_stall = squash ? '0 : (buf_valid & ~grant_next);
  assign accept    = req_valid & ~req_stall & {NUM_REQ{~squash}};

  always_comb begin
    buf_d       = buf_q;
    cdb_d       = TAG_IDLE;
    cdb_value_d = '0;
    cdb_grant_d = '0;
`ifdef CDB_RR_EN
    ptr_d       = ptr_q;
`endif

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_next[i]) begin
        cdb_d.tag       = buf_q[i].tag;
        cdb_d.ready     = 1'b1;
        cdb_d.valid     = 1'b1;
        cdb_value_d     = buf_q[i].value;
        cdb_grant_d[i]  = 1'b1;
        buf_d[i].valid  = 1'b0;
`ifdef CDB_RR_EN
        ptr_d           = PtrW'((i + 1) % NUM_REQ);
`endif
      end
      // Refill after the drain so a same-edge grant and accept keeps the entry.
      if (accept[i]) begin
        buf_d[i].valid = 1'b1;
        buf_d[i].tag   = req_tag[i];
        buf_d[i].value = req_value[i];
      end
    end

    // Flush beats any grant or accept in the same cycle.
    if (squash) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_d[i] = '0;
      end
      cdb_d       = TAG_IDLE;
      cdb_value_d = '0;
      cdb_grant_d = '0;
`ifdef CDB_RR_EN
      ptr_d       = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q       <= '0;
      cdb_q       <= TAG_IDLE;
      cdb_value_q <= '0;
      cdb_grant_q <= '0;
`ifdef CDB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      buf_q       <= buf_d;
      cdb_q       <= cdb_d;
      cdb_value_q <= cdb_value_d;
      cdb_grant_q <= cdb_grant_d;
`ifdef CDB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign cdb       = cdb_q;
  assign cdb_value = cdb_value_q;
  assign cdb_grant = cdb_grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed plus randomized bench for cdb_arbiter. A behavioural model keeps
//   one pending result per functional unit and one buffered result per unit,
//   picks a winner by scanning from the pointer (always 0 for fixed priority),
//   and predicts the stall vector and the next broadcast. Functional units in
//   the bench hold their request while stalled.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = NUM_CDB_REQ;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    squash = 1'b0;
  logic [N-1:0]            req_valid;
  logic [N-1:0][TAG_W-1:0] req_tag;
  logic [N-1:0][31:0]      req_value;
  logic [N-1:0]            req_stall;
  TAG                      cdb;
  logic [31:0]             cdb_value;
  logic [N-1:0]            cdb_grant;

  int checks = 0;
  int errors = 0;
  int mult_ld_grants;

  // Model state: buffered results, pointer, predicted registered outputs.
  bit               m_valid[N];
  logic [TAG_W-1:0] m_tag[N];
  logic [31:0]      m_val[N];
  int               m_ptr;
  TAG               e_cdb;
  logic [31:0]      e_value;
  logic [N-1:0]     e_grant;

  // Functional-unit side: one pending result each.
  bit               fu_pend[N];
  logic [TAG_W-1:0] fu_tag[N];
  logic [31:0]      fu_val[N];

  logic [TAG_W-1:0] bcast_log[$];

  cdb_arbiter #(
    .NUM_REQ (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_stall (req_stall),
    .cdb       (cdb),
    .cdb_value (cdb_value),
    .cdb_grant (cdb_grant)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (m_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr   = 0;
    e_cdb   = '0;
    e_value = '0;
    e_grant = '0;
  endtask

  // One clock cycle, entered just after a falling edge.
  task automatic step();
    int           w;
    logic [N-1:0] exp_stall;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = fu_pend[i];
      req_tag[i]   = fu_tag[i];
      req_value[i] = fu_val[i];
    end
    #1;
    w = pick();
    exp_stall = '0;
    if (reset && !squash) begin
      for (int i = 0; i < N; i++) exp_stall[i] = m_valid[i] && (i != w);
    end
    check("req_stall", 64'(req_stall), 64'(exp_stall));
    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else if (squash) begin
      model_clear();
      for (int i = 0; i < N; i++) fu_pend[i] = 1'b0;
    end else begin
      if (w >= 0) begin
        e_cdb      = '{tag: m_tag[w], ready: 1'b1, valid: 1'b1};
        e_value    = m_val[w];
        e_grant    = N'(1) << w;
        m_valid[w] = 1'b0;
`ifdef CDB_RR_EN
        m_ptr = (w + 1) % N;
`endif
      end else begin
        e_cdb   = '0;
        e_value = '0;
        e_grant = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_pend[i] && !exp_stall[i]) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = fu_tag[i];
          m_val[i]   = fu_val[i];
          fu_pend[i] = 1'b0;
        end
      end
    end
    @(negedge clock);
    check("cdb", 64'(cdb), 64'(e_cdb));
    check("cdb_value", 64'(cdb_value), 64'(e_value));
    check("cdb_grant", 64'(cdb_grant), 64'(e_grant));
    if (cdb.valid === 1'b1) bcast_log.push_back(cdb.tag);
  endtask

  initial begin
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;
    model_clear();

    // Reset held low while all three units request.
    for (int i = 0; i < N; i++) begin
      fu_pend[i] = 1'b1;
      fu_tag[i]  = TAG_W'(i + 1);
      fu_val[i]  = 32'(100 + i);
    end
    @(negedge clock);
    repeat (3) step();
    check("rst_cdb_valid", 64'(cdb.valid), 64'(0));
    check("rst_grant", 64'(cdb_grant), 64'(0));

    // Release: accept at E1, broadcasts of 1, 2, 3 from E2 onward.
    reset = 1'b1;
    bcast_log.delete();
    step();
    check("first_edge_idle", 64'(cdb.valid), 64'(0));
    repeat (3) step();
    check("order_len", 64'(bcast_log.size()), 64'(3));
    for (int i = 0; i < 3; i++) check("order_tag", 64'(bcast_log[i]), 64'(i + 1));
    step();

    // Single ALU request, tag 5, value 0x10.
    fu_pend[CDB_REQ_ALU] = 1'b1;
    fu_tag[CDB_REQ_ALU]  = 6'd5;
    fu_val[CDB_REQ_ALU]  = 32'h10;
    step();
    step();
    check("alu_cdb", 64'(cdb), 64'({6'd5, 1'b1, 1'b1}));
    check("alu_value", 64'(cdb_value), 64'h10);
    check("alu_grant", 64'(cdb_grant), 64'b001);
    step();
    check("alu_idle", 64'(cdb.valid), 64'(0));

    // ALU streams new tags while MULT and LD each request once.
    fu_pend[CDB_REQ_MULT] = 1'b1; fu_tag[CDB_REQ_MULT] = 6'd11; fu_val[CDB_REQ_MULT] = 32'hB;
    fu_pend[CDB_REQ_LD]   = 1'b1; fu_tag[CDB_REQ_LD]   = 6'd12; fu_val[CDB_REQ_LD]   = 32'hC;
    mult_ld_grants = 0;
    for (int c = 0; c < 6; c++) begin
      if (!fu_pend[CDB_REQ_ALU]) begin
        fu_pend[CDB_REQ_ALU] = 1'b1;
        fu_tag[CDB_REQ_ALU]  = TAG_W'(20 + c);
        fu_val[CDB_REQ_ALU]  = 32'(c);
      end
      step();
      if (cdb_grant[2:1] != 2'b00) mult_ld_grants++;
    end
`ifdef CDB_RR_EN
    check("rr_share", 64'(mult_ld_grants), 64'(2));
`else
    check("fixed_starve", 64'(mult_ld_grants), 64'(0));
`endif
    repeat (6) step();

    // MULT granted and refilled on the same edge: back-to-back broadcast.
    fu_pend[CDB_REQ_MULT] = 1'b1; fu_tag[CDB_REQ_MULT] = 6'd8; fu_val[CDB_REQ_MULT] = 32'h88;
    step();
    fu_pend[CDB_REQ_MULT] = 1'b1; fu_tag[CDB_REQ_MULT] = 6'd9; fu_val[CDB_REQ_MULT] = 32'h99;
    step();
    check("b2b_tag8", 64'(cdb.tag), 64'(8));
    step();
    check("b2b_tag9", 64'(cdb.tag), 64'(9));
    check("b2b_grant", 64'(cdb_grant), 64'b010);
    step();

    // Two buffers full, then squash with a new request presented.
    fu_pend[CDB_REQ_ALU] = 1'b1; fu_tag[CDB_REQ_ALU] = 6'd40; fu_val[CDB_REQ_ALU] = 32'h40;
    fu_pend[CDB_REQ_LD]  = 1'b1; fu_tag[CDB_REQ_LD]  = 6'd42; fu_val[CDB_REQ_LD]  = 32'h42;
    step();
    squash = 1'b1;
    fu_pend[CDB_REQ_MULT] = 1'b1; fu_tag[CDB_REQ_MULT] = 6'd41; fu_val[CDB_REQ_MULT] = 32'h41;
    step();
    squash = 1'b0;
    check("sq_idle", 64'(cdb.valid), 64'(0));
    bcast_log.delete();
    repeat (3) step();
    check("sq_no_bcast", 64'(bcast_log.size()), 64'(0));
    fu_pend[CDB_REQ_LD] = 1'b1; fu_tag[CDB_REQ_LD] = 6'd43; fu_val[CDB_REQ_LD] = 32'h43;
    step();
    step();
    check("post_sq_tag", 64'(cdb.tag), 64'(43));
    check("post_sq_valid", 64'(cdb.valid), 64'(1));
    step();

    // Asynchronous reset in the middle of a cycle with a broadcast on the bus.
    fu_pend[CDB_REQ_ALU]  = 1'b1; fu_tag[CDB_REQ_ALU]  = 6'd50; fu_val[CDB_REQ_ALU]  = 32'h50;
    fu_pend[CDB_REQ_MULT] = 1'b1; fu_tag[CDB_REQ_MULT] = 6'd51; fu_val[CDB_REQ_MULT] = 32'h51;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check("async_cdb", 64'(cdb), 64'(0));
    check("async_grant", 64'(cdb_grant), 64'(0));
    check("async_stall", 64'(req_stall), 64'(0));
    model_clear();
    @(negedge clock);
    step();
    reset = 1'b1;
    bcast_log.delete();
    repeat (2) step();
    check("async_no_stale", 64'(bcast_log.size()), 64'(0));

    // Randomized traffic with occasional squash.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!fu_pend[i] && ($urandom_range(0, 1) == 1)) begin
          fu_pend[i] = 1'b1;
          fu_tag[i]  = TAG_W'($urandom);
          fu_val[i]  = $urandom;
        end
      end
      squash = ($urandom_range(0, 31) == 0);
      step();
      squash = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Collects completed results from the functional units (ALU, MULT, LD) and arbitrates them onto the single common data bus (CDB).
- The reservation station and map table consume the CDB to wake up waiting operands.
- Each requester has a one-entry holding buffer, so a functional unit can retire a result and move on while it waits for the bus.
- Sits between the execute stage and the reservation station; exactly one broadcast per cycle.

## Interface
- NUM_REQ, default 3 — number of requesting functional units; index 0 = ALU, 1 = MULT, 2 = LD.
- clock  input  1  — system clock, all state updates on posedge.
- reset  input  1  — asynchronous, active-low; asserting (0) clears all state immediately.
- squash  input  1  — synchronous flush on mispredict; drops all buffered and outgoing results.
- req_valid  input  NUM_REQ  — per-FU result valid.
- req_tag  input  NUM_REQ x TAG_W  — destination physical tag per FU.
- req_value  input  NUM_REQ x 32  — result data per FU.
- req_stall  output  NUM_REQ  — combinational; FU must hold its request while high.
- cdb  output  TAG  — registered broadcast (tag/ready/valid fields), same type the RS `cdb` port takes.
- cdb_value  output  32  — registered result data, aligned with cdb.
- cdb_grant  output  NUM_REQ  — registered one-hot, identifies the source of the current broadcast.

## Operation
- Per-requester buffer: buf_valid, buf_tag, buf_value.
- Accept rule: req_valid[i] & ~req_stall[i] writes buffer i at posedge.
- req_stall[i] = buf_valid[i] & ~grant_next[i]. When the entry is granted this cycle, the buffer drains and refills on the same edge (full throughput).
- Arbitration: combinational over buf_valid only; new inputs never bypass to the bus. Exactly one winner per cycle (grant_next one-hot or zero).
- On posedge with a winner w:
  - cdb.tag = buf_tag[w], cdb.ready = 1, cdb.valid = 1
  - cdb_value = buf_value[w]
  - cdb_grant = one-hot(w)
  - buf_valid[w] cleared unless refilled.
- With no winner: cdb = {tag 0, ready 0, valid 0}, cdb_value = 0, cdb_grant = 0.
- squash has priority over everything at posedge: all buf_valid = 0, cdb/cdb_value/cdb_grant idle. Requests presented in the squash cycle are dropped and req_stall is forced to 0 that cycle.
- TAG_W equals the width of the TAG.tag field from sys_defs.svh; tags pass through unmodified.

## Timing
- Reset (reset = 0, asynchronous) values:
  - all buf_valid = 0
  - cdb tag/ready/valid = 0; cdb_value = 0; cdb_grant = 0
  - round-robin pointer = 0
  - req_stall = 0 as a consequence.
- Latency: request sampled at edge E1 is buffered after E1; the earliest it can appear on cdb is after E2 (2-edge minimum).
- cdb is valid for exactly one cycle per granted result; it never repeats the same entry.
- All NUM_REQ buffers full, no squash: one grant per cycle. The others stall, and their FUs hold req_valid/tag/value stable.
- Reset deasserted mid-operation: state resumes from the reset values; no partial broadcast.

## Configuration
- CDB_RR_EN defined: round-robin. The pointer p starts the search at index p; after granting w, p = (w+1) mod NUM_REQ. The pointer updates only on a grant and resets to 0 on reset or squash.
- CDB_RR_EN undefined: fixed priority, lowest index wins (ALU > MULT > LD). No pointer register exists.

## Structure
- In sys_defs.svh:
  - NUM_CDB_REQ
  - CDB_REQ_ALU/CDB_REQ_MULT/CDB_REQ_LD index constants
  - CDB_REQ typedef struct {valid, tag, value}
  - reuse of the existing TAG typedef.
- One sub-module, cdb_rr_pick: combinational masked priority picker, inputs (valid vector, start pointer), output one-hot. With CDB_RR_EN undefined it is instantiated with the pointer tied to 0.

## Test plan
- Reset held low with req_valid = 3'b111 → cdb.valid = 0, cdb_grant = 0, req_stall = 0 throughout. After release, the first broadcast appears 2 edges later.
- Single ALU request, tag 5, value 32'h10 at E1 → after E2: cdb = {tag 5, ready 1, valid 1}, cdb_value 32'h10, cdb_grant 3'b001. After E3: idle.
- All three FUs request at E1 (tags 1, 2, 3), held while stalled, with CDB_RR_EN → broadcasts of tags 1, 2, 3 on three consecutive cycles. req_stall[2] high for two cycles.
- Same stimulus without CDB_RR_EN, ALU re-requesting new tags every cycle → MULT and LD starve while the ALU streams; order is ALU-only.
- MULT buffer full, granted this cycle, new MULT request (tag 9) the same cycle → req_stall[1] = 0, tag 9 broadcast the next cycle (back-to-back).
- Two buffers full, squash pulsed → after the edge, cdb.valid = 0 and no buffered tag is ever broadcast; a new request after squash is broadcast 2 edges later.
